// File: rtl/msg_pkg.sv
// msg_pkg: message text, lengths and FSM state shared by msg_seq and msg_rom.
// Defining MSG_SEQ_NEWLINE_EN appends a 0x0A after the final message character.
package msg_pkg;
    localparam int unsigned MSG_LEN = 14;
    localparam logic [8*MSG_LEN-1:0] MSG_TEXT = "Hello There !!";
    localparam logic [7:0] NEWLINE_CH = 8'h0A;
`ifdef MSG_SEQ_NEWLINE_EN
    localparam int unsigned MSG_TOTAL = MSG_LEN + 1;
`else
    localparam int unsigned MSG_TOTAL = MSG_LEN;
`endif
    localparam int unsigned IDX_W = 4;
    typedef enum logic {ST_WAIT = 1'b0, ST_SEND = 1'b1} state_e;
endpackage

// File: rtl/msg_rom.sv
// msg_rom: combinational character-index to ASCII lookup for the fixed message.
// MSG_SEQ_NEWLINE_EN places a newline in the slot after the last message character.
module msg_rom
    import msg_pkg::*;
(
    input  logic [IDX_W-1:0] idx_i,
    output logic [7:0]       char_o
);
`ifdef MSG_SEQ_NEWLINE_EN
    localparam logic [7:0] TAIL_CH = NEWLINE_CH;
`else
    localparam logic [7:0] TAIL_CH = 8'h00;
`endif
    // Index 0 sits in the top byte; indices past the message read 0x00.
    localparam logic [127:0] ROM_BYTES = {MSG_TEXT, TAIL_CH, 8'h00};
    assign char_o = ROM_BYTES[{4'd15 - idx_i, 3'b000} +: 8];
endmodule

// File: rtl/msg_seq.sv
// msg_seq: periodically streams a fixed message over a valid/ready character interface.
// Build with MSG_SEQ_NEWLINE_EN defined to terminate each message with 0x0A.
module msg_seq
    import msg_pkg::*;
#(
    parameter int unsigned PERIOD = 16,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    output logic [7:0]       char_data,
    output logic             char_valid,
    input  logic             char_ready,
    output logic             msg_start,
    output logic             msg_done,
    output logic             busy,
    output logic [CNT_W-1:0] msg_count
);
    localparam logic [15:0]      LAST_CNT = 16'(PERIOD - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_TOTAL - 1);

    state_e           state_q;
    logic [15:0]      cnt_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] rom_idx;
    logic [7:0]       char_data_q;
    logic [7:0]       rom_char;
    logic             char_valid_q;
    logic             msg_start_q;
    logic             msg_done_q;
    logic             busy_q;
    logic [CNT_W-1:0] msg_count_q;
    logic             go;
    logic             hs;

    assign go = (state_q == ST_WAIT) && (cnt_q == LAST_CNT) && enable;
    assign hs = char_valid_q && char_ready;
    // The ROM is addressed with the character that will be registered on the next edge.
    assign rom_idx = go ? '0 : idx_q + 1'b1;

    msg_rom u_rom (
        .idx_i  (rom_idx),
        .char_o (rom_char)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_WAIT;
            cnt_q        <= '0;
            idx_q        <= '0;
            char_data_q  <= 8'h00;
            char_valid_q <= 1'b0;
            msg_start_q  <= 1'b0;
            msg_done_q   <= 1'b0;
            busy_q       <= 1'b0;
            msg_count_q  <= '0;
        end else begin
            msg_start_q <= 1'b0;
            msg_done_q  <= 1'b0;
            if (state_q == ST_WAIT) begin
                if (go) begin
                    state_q      <= ST_SEND;
                    idx_q        <= '0;
                    char_data_q  <= rom_char;
                    char_valid_q <= 1'b1;
                    msg_start_q  <= 1'b1;
                    busy_q       <= 1'b1;
                end else if (cnt_q != LAST_CNT) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else if (hs) begin
                if (idx_q == LAST_IDX) begin
                    state_q      <= ST_WAIT;
                    cnt_q        <= '0;
                    idx_q        <= '0;
                    char_data_q  <= 8'h00;
                    char_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                    msg_done_q   <= 1'b1;
                    msg_count_q  <= msg_count_q + 1'b1;
                end else begin
                    idx_q       <= idx_q + 1'b1;
                    char_data_q <= rom_char;
                end
            end
        end
    end

    assign char_data  = char_data_q;
    assign char_valid = char_valid_q;
    assign msg_start  = msg_start_q;
    assign msg_done   = msg_done_q;
    assign busy       = busy_q;
    assign msg_count  = msg_count_q;
endmodule

// File: tb/tb_msg_seq.sv
// tb_msg_seq: directed and randomized checks of msg_seq against a message-level reference model.
// Honours MSG_SEQ_NEWLINE_EN the same way as the design.
module tb_msg_seq;
    localparam int PERIOD = 4;
    localparam int CNT_W  = 2;
`ifdef MSG_SEQ_NEWLINE_EN
    localparam int L = 15;
`else
    localparam int L = 14;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             enable = 1'b0;
    logic             char_ready = 1'b0;
    logic [7:0]       char_data;
    logic             char_valid;
    logic             msg_start;
    logic             msg_done;
    logic             busy;
    logic [CNT_W-1:0] msg_count;

    always #5 clk = ~clk;

    msg_seq #(.PERIOD(PERIOD), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .char_data  (char_data),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .msg_start  (msg_start),
        .msg_done   (msg_done),
        .busy       (busy),
        .msg_count  (msg_count)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    byte unsigned exp_msg [L];
    byte unsigned rx [$];
    bit          in_msg;
    int          k;
    int          since;
    int          done_n;
    int          edge_n;
    int          wrap_seq [5] = '{1, 2, 3, 0, 1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        in_msg = 1'b0;
        k      = 0;
        since  = 0;
        done_n = 0;
        edge_n = 0;
        rx.delete();
    endtask

    task automatic tick();
        bit hs, st, dn, ok;
        hs = in_msg && char_ready;
        st = !in_msg && (since + 1 >= PERIOD) && enable;
        dn = hs && (k == L - 1);
        if (hs) rx.push_back(char_data);
        @(posedge clk);
        #2;
        edge_n++;
        if (st) begin
            in_msg = 1'b1;
            k = 0;
            rx.delete();
        end else if (dn) begin
            in_msg = 1'b0;
            since = 0;
            done_n++;
        end else if (hs) begin
            k++;
        end else if (!in_msg) begin
            since++;
        end
        chk("msg_start", msg_start, st);
        chk("msg_done", msg_done, dn);
        chk("busy", busy, in_msg);
        chk("char_valid", char_valid, in_msg);
        chk("msg_count", msg_count, done_n % 4);
        if (in_msg) chk("char_data", char_data, exp_msg[k]);
        if (dn) begin
            ok = (rx.size() == L);
            for (int i = 0; i < L && ok; i++) ok = (rx[i] == exp_msg[i]);
            chk("msg_stream", ok, 1);
        end
    endtask

    task automatic wait_start();
        int i = 0;
        do begin
            tick();
            i++;
        end while (!msg_start && i < 64);
        chk("start_seen", msg_start, 1);
    endtask

    task automatic wait_done();
        int i = 0;
        do begin
            tick();
            i++;
        end while (!msg_done && i < 400);
        chk("done_seen", msg_done, 1);
    endtask

    task automatic wait_idx(input int n);
        int i = 0;
        while (!(in_msg && k == n) && i < 64) begin
            tick();
            i++;
        end
        chk("reach_idx", busy, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_char_data"}, char_data, 8'h00);
        chk({tag, "_char_valid"}, char_valid, 0);
        chk({tag, "_msg_start"}, msg_start, 0);
        chk({tag, "_msg_done"}, msg_done, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_msg_count"}, msg_count, 0);
    endtask

    task automatic async_reset();
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("rst_async");
        @(posedge clk);
        #2;
        check_reset_outputs("rst_held");
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        string s;
        s = "Hello There !!";
        for (int i = 0; i < 14; i++) exp_msg[i] = s[i];
`ifdef MSG_SEQ_NEWLINE_EN
        exp_msg[14] = 8'h0A;
`endif
        model_reset();
        #1 check_reset_outputs("rst_init");
        #2 rst_n = 1'b1;
        enable = 1'b1;
        char_ready = 1'b1;

        // First message: start timing, full stream, count
        wait_start();
        chk("first_start_edge", edge_n, PERIOD);
        chk("first_char", char_data, 8'h48);
        wait_done();
        chk("count_after_first", msg_count, 1);

        // Backpressure while 'e' is offered
        wait_start();
        wait_idx(1);
        char_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_data", char_data, 8'h65);
            chk("stall_valid", char_valid, 1);
        end
        char_ready = 1'b1;
        wait_done();

        // Enable dropped mid-message: message completes, restart waits for enable
        wait_start();
        wait_idx(5);
        enable = 1'b0;
        wait_done();
        for (int i = 0; i < 10; i++) tick();
        enable = 1'b1;
        tick();
        chk("resume_start", msg_start, 1);
        wait_done();

        // Reset in the middle of a message
        wait_start();
        wait_idx(7);
        async_reset();
        wait_start();
        chk("restart_edge", edge_n, PERIOD);
        chk("restart_char", char_data, 8'h48);
        wait_done();

        // msg_count wrap with a 2-bit counter
        async_reset();
        for (int i = 0; i < 5; i++) begin
            wait_done();
            chk("wrap_seq", msg_count, wrap_seq[i]);
        end

        // Randomized enable and backpressure
        for (int i = 0; i < 1500; i++) begin
            char_ready = ($urandom_range(0, 3) != 0);
            enable = ($urandom_range(0, 7) != 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
